// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32IM divider.
package div_pkg;

  // Encodings match funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StSign = 2'b10,
    StDone = 2'b11
  } div_state_t;

  // Widest operand abs_val handles; callers truncate back to their own width.
  localparam int unsigned MaxWidth = 64;

  function automatic logic [MaxWidth-1:0] abs_val(input logic [MaxWidth-1:0] val,
                                                  input logic neg);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left and try to subtract the divisor.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] rem_shift;
  logic [DATA_WIDTH:0] trial;

  // rem < divisor keeps the true difference inside +/-2^W, so bit W is a valid sign.
  always_comb begin
    rem_shift = {rem, quo[DATA_WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor};
    if (!trial[DATA_WIDTH]) begin
      rem_next = trial[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_rem_seq.sv
// Iterative DIV/DIVU/REM/REMU unit: one restoring step per clock, special cases in one cycle.
module div_rem_seq
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state_q;
  div_op_t               op_q;
  logic                  quo_neg_q, rem_neg_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q, result_q;
  logic [CntW-1:0]       cnt_q;

  logic                  op_signed, a_neg, b_neg, is_rem;
  logic                  div_zero, overflow;
  logic [DATA_WIDTH-1:0] special_res, a_mag, b_mag;
  logic [DATA_WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

  assign op_signed = ~op[0];
  assign is_rem    = op[1];
  assign a_neg     = op_signed & op_a[DATA_WIDTH-1];
  assign b_neg     = op_signed & op_b[DATA_WIDTH-1];
  assign div_zero  = (op_b == '0);
  assign overflow  = op_signed && (op_a == MinVal) && (op_b == '1);
  assign a_mag     = DATA_WIDTH'(abs_val(MaxWidth'(op_a), a_neg));
  assign b_mag     = DATA_WIDTH'(abs_val(MaxWidth'(op_b), b_neg));

  // Divide-by-zero wins over overflow; both bypass the iteration.
  always_comb begin
    if (div_zero) begin
      special_res = is_rem ? op_a : '1;
    end else begin
      special_res = is_rem ? '0 : MinVal;
    end
  end

  assign quo_fix = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (div_q),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpDiv;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            op_q      <= div_op_t'(op);
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (div_zero || overflow) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              quo_q   <= a_mag;
              div_q   <= b_mag;
              rem_q   <= '0;
              cnt_q   <= CntW'(DATA_WIDTH - 1);
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) begin
            state_q <= StSign;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSign: begin
          result_q <= (op_q == OpRem || op_q == OpRemu) ? rem_fix : quo_fix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
